// File: rtl/afifo_pack_pkg.sv
// Shared types and helpers for the FIFO read-side word packer.
// Optional parity output is enabled with AFIFO_PACK_PARITY_EN.
package afifo_pack_pkg;

    typedef enum logic [1:0] {
        FILL       = 2'd0,
        FLUSH_WAIT = 2'd1,
        FLUSH_EMIT = 2'd2
    } pack_state_e;

    localparam int unsigned PACK_RATIO_MIN = 2;
    localparam int unsigned PACK_RATIO_MAX = 16;
    localparam int unsigned CNT_ARG_W      = 5;

    // Low 'count' bits set; callers truncate to their PACK_RATIO.
    function automatic logic [PACK_RATIO_MAX-1:0] keep_mask(input logic [CNT_ARG_W-1:0] count);
        logic [PACK_RATIO_MAX-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < PACK_RATIO_MAX; i++) begin
            if (CNT_ARG_W'(i) < count) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/afifo_beat_reg.sv
// Single-entry valid/ready holding register for a packed beat.
// Carries the per-slot parity only when AFIFO_PACK_PARITY_EN is defined.
module afifo_beat_reg #(
    parameter int unsigned BEAT_WIDTH = 32,
    parameter int unsigned KEEP_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [BEAT_WIDTH-1:0] data_i,
    input  logic [KEEP_WIDTH-1:0] keep_i,
`ifdef AFIFO_PACK_PARITY_EN
    input  logic [KEEP_WIDTH-1:0] parity_i,
    output logic [KEEP_WIDTH-1:0] parity_o,
`endif
    input  logic                  ready_i,
    output logic                  free_c_o,
    output logic                  valid_o,
    output logic [BEAT_WIDTH-1:0] data_o,
    output logic [KEEP_WIDTH-1:0] keep_o
);

    assign free_c_o = !valid_o || ready_i;

    // Payload only changes on load, so it stays stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o  <= 1'b0;
            data_o   <= '0;
            keep_o   <= '0;
`ifdef AFIFO_PACK_PARITY_EN
            parity_o <= '0;
`endif
        end else if (load_i) begin
            valid_o  <= 1'b1;
            data_o   <= data_i;
            keep_o   <= keep_i;
`ifdef AFIFO_PACK_PARITY_EN
            parity_o <= parity_i;
`endif
        end else if (ready_i) begin
            valid_o  <= 1'b0;
        end
    end

endmodule

// File: rtl/afifo_word_packer.sv
// Packs PACK_RATIO FIFO words into one beat; flush emits a keep-masked partial beat.
// Define AFIFO_PACK_PARITY_EN to add the Beat_Parity_out port.
module afifo_word_packer
    import afifo_pack_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PACK_RATIO = 4,
    localparam int unsigned BEAT_WIDTH = DATA_WIDTH * PACK_RATIO
) (
    input  logic                  Clk,
    input  logic                  Reset_n_in,
    input  logic [DATA_WIDTH-1:0] Fifo_Data_in,
    input  logic                  Fifo_Empty_in,
    output logic                  Fifo_ReadEn_out,
    input  logic                  Flush_in,
    output logic                  Flush_Done_out,
    output logic [BEAT_WIDTH-1:0] Beat_Data_out,
    output logic [PACK_RATIO-1:0] Beat_Keep_out,
`ifdef AFIFO_PACK_PARITY_EN
    output logic [PACK_RATIO-1:0] Beat_Parity_out,
`endif
    output logic                  Beat_Valid_out,
    input  logic                  Beat_Ready_in
);

    localparam int unsigned CNT_W = $clog2(PACK_RATIO + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PACK_RATIO);

    if (PACK_RATIO < PACK_RATIO_MIN || PACK_RATIO > PACK_RATIO_MAX) begin : g_bad_ratio
        $error("afifo_word_packer: PACK_RATIO out of range");
    end

    pack_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  pending_q;
    logic [BEAT_WIDTH-1:0] acc_q, acc_d;
    logic                  flush_done_q, flush_done_d;

    logic                  free_c;
    logic                  xfer_c;
    logic                  emit_c;
    logic                  load_c;
    logic                  accept_c;
    logic [CNT_W-1:0]      fill_lvl_c;
    logic [PACK_RATIO-1:0] keep_c;
    logic [BEAT_WIDTH-1:0] beat_data_c;

    assign fill_lvl_c = CNT_W'(cnt_q + CNT_W'(pending_q));
    assign xfer_c     = (cnt_q == CNT_FULL) && free_c;
    assign load_c     = xfer_c || emit_c;

    // Reads are gated by reset so the port is low for the whole reset window.
    assign Fifo_ReadEn_out = Reset_n_in && (state_q == FILL) && !Flush_in && !Fifo_Empty_in
                             && ((fill_lvl_c < CNT_FULL) || xfer_c);
    assign accept_c        = Fifo_ReadEn_out && !Fifo_Empty_in;
    assign Flush_Done_out  = flush_done_q;

    // Keep follows cnt: all ones for a full beat, low cnt bits for a partial one.
    always_comb begin
        keep_c      = PACK_RATIO'(keep_mask(CNT_ARG_W'(cnt_q)));
        beat_data_c = '0;
        for (int unsigned k = 0; k < PACK_RATIO; k++) begin
            if (keep_c[k]) beat_data_c[k*DATA_WIDTH +: DATA_WIDTH] = acc_q[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

`ifdef AFIFO_PACK_PARITY_EN
    logic [PACK_RATIO-1:0] beat_par_c;

    always_comb begin
        beat_par_c = '0;
        for (int unsigned k = 0; k < PACK_RATIO; k++) begin
            beat_par_c[k] = ^beat_data_c[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end
`endif

    // Flush sequencing.
    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        emit_c       = 1'b0;
        case (state_q)
            FILL: begin
                if (Flush_in) state_d = FLUSH_WAIT;
            end
            FLUSH_WAIT: begin
                if (!pending_q) begin
                    if (cnt_q == '0) begin
                        flush_done_d = 1'b1;
                        state_d      = FILL;
                    end else if (cnt_q != CNT_FULL) begin
                        state_d = FLUSH_EMIT;
                    end
                end
            end
            FLUSH_EMIT: begin
                if (free_c) begin
                    emit_c       = 1'b1;
                    flush_done_d = 1'b1;
                    state_d      = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Accumulator: the registered read word lands in slot cnt.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (pending_q) begin
            for (int unsigned k = 0; k < PACK_RATIO; k++) begin
                if (cnt_q == CNT_W'(k)) acc_d[k*DATA_WIDTH +: DATA_WIDTH] = Fifo_Data_in;
            end
            cnt_d = CNT_W'(cnt_q + 1'b1);
        end
        if (load_c) cnt_d = '0;
    end

    always_ff @(posedge Clk or negedge Reset_n_in) begin
        if (!Reset_n_in) begin
            state_q      <= FILL;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            acc_q        <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pending_q    <= accept_c;
            acc_q        <= acc_d;
            flush_done_q <= flush_done_d;
        end
    end

    afifo_beat_reg #(
        .BEAT_WIDTH (BEAT_WIDTH),
        .KEEP_WIDTH (PACK_RATIO)
    ) u_beat_reg (
        .clk      (Clk),
        .rst_n    (Reset_n_in),
        .load_i   (load_c),
        .data_i   (beat_data_c),
        .keep_i   (keep_c),
`ifdef AFIFO_PACK_PARITY_EN
        .parity_i (beat_par_c),
        .parity_o (Beat_Parity_out),
`endif
        .ready_i  (Beat_Ready_in),
        .free_c_o (free_c),
        .valid_o  (Beat_Valid_out),
        .data_o   (Beat_Data_out),
        .keep_o   (Beat_Keep_out)
    );

endmodule

// File: tb/tb_afifo_word_packer.sv
// Directed bench for afifo_word_packer (DATA_WIDTH=8, PACK_RATIO=4) with a small FIFO model.
module tb_afifo_word_packer;

    localparam int unsigned DW = 8;
    localparam int unsigned PR = 4;
    localparam int unsigned BW = DW * PR;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_empty;
    logic          rd_en;
    logic          flush = 1'b0;
    logic          flush_done;
    logic [BW-1:0] beat_data;
    logic [PR-1:0] beat_keep;
    logic          beat_valid;
    logic          beat_ready = 1'b1;
`ifdef AFIFO_PACK_PARITY_EN
    logic [PR-1:0] beat_par;
`endif

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] src_mem [0:63];
    int src_n = 0;
    int rd_ptr = 0;

    always #5 clk = ~clk;

    afifo_word_packer #(
        .DATA_WIDTH (DW),
        .PACK_RATIO (PR)
    ) dut (
        .Clk             (clk),
        .Reset_n_in      (rst_n),
        .Fifo_Data_in    (fifo_data),
        .Fifo_Empty_in   (fifo_empty),
        .Fifo_ReadEn_out (rd_en),
        .Flush_in        (flush),
        .Flush_Done_out  (flush_done),
        .Beat_Data_out   (beat_data),
        .Beat_Keep_out   (beat_keep),
`ifdef AFIFO_PACK_PARITY_EN
        .Beat_Parity_out (beat_par),
`endif
        .Beat_Valid_out  (beat_valid),
        .Beat_Ready_in   (beat_ready)
    );

    // FIFO read port with one-cycle registered data; reset drops queued words.
    assign fifo_empty = (rd_ptr >= src_n);

    always @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= src_n;
        end else if (rd_en && !fifo_empty) begin
            fifo_data <= src_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic push(input logic [DW-1:0] w);
        src_mem[src_n] = w;
        src_n = src_n + 1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (!beat_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(beat_valid), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(beat_valid), 64'd0);
        chk("rst_data",  64'(beat_data),  64'd0);
        chk("rst_keep",  64'(beat_keep),  64'd0);
        chk("rst_done",  64'(flush_done), 64'd0);
        chk("rst_rden",  64'(rd_en),      64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Stream of four words, downstream always ready
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        #1;
        chk("stream_rden", 64'(rd_en), 64'd1);
        wait_valid("stream_valid_seen", 20);
        chk("stream_data", 64'(beat_data), 64'h44332211);
        chk("stream_keep", 64'(beat_keep), 64'hF);
        @(negedge clk);
        chk("stream_valid_1cyc", 64'(beat_valid), 64'd0);

        // Backpressure: eight words, downstream stalled
        beat_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        repeat (20) @(negedge clk);
        chk("bp_hold_valid", 64'(beat_valid), 64'd1);
        chk("bp_hold_data",  64'(beat_data),  64'h04030201);
        chk("bp_hold_keep",  64'(beat_keep),  64'hF);
        chk("bp_rden_low",   64'(rd_en),      64'd0);
        chk("bp_all_read",   64'(fifo_empty), 64'd1);
        beat_ready = 1'b1;
        @(negedge clk);
        chk("bp_beat2_valid", 64'(beat_valid), 64'd1);
        chk("bp_beat2_data",  64'(beat_data),  64'h08070605);
        @(negedge clk);
        chk("bp_drained", 64'(beat_valid), 64'd0);

        // Partial flush after three words
        push(8'hA1); push(8'hA2); push(8'hA3);
        repeat (6) @(negedge clk);
        chk("pf_no_beat", 64'(beat_valid), 64'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_valid("pf_valid_seen", 10);
        chk("pf_data", 64'(beat_data),  64'h00A3A2A1);
        chk("pf_keep", 64'(beat_keep),  64'h7);
        chk("pf_done", 64'(flush_done), 64'd1);
`ifdef AFIFO_PACK_PARITY_EN
        chk("pf_parity", 64'(beat_par), 64'h3);
`endif
        @(negedge clk);
        chk("pf_done_pulse", 64'(flush_done), 64'd0);
        chk("pf_valid_drop", 64'(beat_valid), 64'd0);

        // Flush with an empty accumulator
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("ef_done_early", 64'(flush_done), 64'd0);
        @(negedge clk);
        chk("ef_done",     64'(flush_done), 64'd1);
        chk("ef_no_beat",  64'(beat_valid), 64'd0);
        @(negedge clk);
        chk("ef_done_end", 64'(flush_done), 64'd0);

        // FIFO goes empty right after an accepted read
        push(8'h5A);
        #1;
        chk("ee_rden_hi", 64'(rd_en), 64'd1);
        @(negedge clk);
        chk("ee_empty", 64'(fifo_empty), 64'd1);
        chk("ee_rden_lo", 64'(rd_en), 64'd0);
        repeat (3) @(negedge clk);
        chk("ee_rden_stays_lo", 64'(rd_en), 64'd0);
        push(8'h6B); push(8'h7C); push(8'h8D);
        wait_valid("ee_valid_seen", 20);
        chk("ee_data", 64'(beat_data), 64'h8D7C6B5A);
        @(negedge clk);

        // Flush arriving in the same cycle as a full-beat transfer
        @(negedge clk);
        push(8'hE1); push(8'hE2); push(8'hE3); push(8'hE4);
        repeat (5) @(negedge clk);
        chk("fx_pre_valid", 64'(beat_valid), 64'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fx_valid", 64'(beat_valid), 64'd1);
        chk("fx_data",  64'(beat_data),  64'hE4E3E2E1);
        chk("fx_keep",  64'(beat_keep),  64'hF);
        chk("fx_done_not_yet", 64'(flush_done), 64'd0);
        @(negedge clk);
        chk("fx_done", 64'(flush_done), 64'd1);
        chk("fx_no_second_beat", 64'(beat_valid), 64'd0);
        @(negedge clk);

        // Reset mid-stream with a held beat and a partial accumulator
        beat_ready = 1'b0;
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4); push(8'hC5); push(8'hC6);
        repeat (15) @(negedge clk);
        chk("mr_pre_data", 64'(beat_data), 64'hC4C3C2C1);
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 64'(beat_valid), 64'd0);
        chk("mr_data",  64'(beat_data),  64'd0);
        chk("mr_keep",  64'(beat_keep),  64'd0);
        chk("mr_done",  64'(flush_done), 64'd0);
        chk("mr_rden",  64'(rd_en),      64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        beat_ready = 1'b1;
        @(negedge clk);
        push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
        wait_valid("mr_valid_seen", 20);
        chk("mr_post_data", 64'(beat_data), 64'hD4D3D2D1);
        chk("mr_post_keep", 64'(beat_keep), 64'hF);
        @(negedge clk);
        chk("mr_post_drop", 64'(beat_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
